// File: rtl/rapid_pkg.sv
// Shared types and constants for the rapid pipeline front end.
// Holds the IF state encoding and the IF-to-decode payload.
package rapid_pkg;

    localparam int          IF_XLEN      = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          WORD_WIDTH   = 4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        NEXT  = 2'd2,
        HALT  = 2'd3
    } IF_state_t;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
    } if_id_s;

endpackage

// File: rtl/rapid_fetch.sv
// Instruction-fetch stage: one outstanding word fetch, redirect/halt sequencing,
// and a valid/ready output register toward decode.
module rapid_fetch
    import rapid_pkg::*;
#(
    parameter int              XLEN     = IF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
    parameter int              PC_STEP  = WORD_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [1:0]      if_state
);

    IF_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            squash_q, squash_d;
    logic            out_valid_q, out_valid_d;
    if_id_s          out_q, out_d;

    logic            req_fire;
    logic [XLEN-1:0] redirect_aligned;
    logic [XLEN-1:0] pc_next;

    // Reset gates the request so nothing is issued while the state register reloads.
    assign imem_req_valid   = (state_q == FETCH) && !halt_req && !reset;
    assign imem_req_addr    = {pc_q[XLEN-1:2], 2'b00};
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc_next          = pc_q + XLEN'(PC_STEP);

    assign if_valid = out_valid_q;
    assign if_pc    = out_q.pc;
    assign if_instr = out_q.instr;
    assign if_state = state_q;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        squash_d    = squash_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;

        if (redirect_valid) begin
            // A redirect kills the presented instruction even if decode takes it now.
            pc_d        = redirect_aligned;
            out_valid_d = 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (req_fire) begin
                        squash_d = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        state_d  = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        squash_d = 1'b0;
                        state_d  = FETCH;
                    end else begin
                        squash_d = 1'b1;
                    end
                end
                default: state_d = FETCH;
            endcase
        end else begin
            if (out_valid_q && if_ready) begin
                out_valid_d = 1'b0;
            end
            unique case (state_q)
                FETCH: begin
                    if (req_fire) begin
                        state_d = WAIT;
                    end else if (halt_req) begin
                        state_d = HALT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = halt_req ? HALT : FETCH;
                        end else begin
                            out_d.pc    = pc_q;
                            out_d.instr = imem_resp_data;
                            out_valid_d = 1'b1;
                            state_d     = NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (out_valid_q && if_ready) begin
                        pc_d    = pc_next;
                        state_d = halt_req ? HALT : FETCH;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments and reset is sampled
    // on the clock edge, so every register sees the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            squash_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_rapid_fetch.sv
// Self-checking bench for rapid_fetch: a latency-programmable memory responder
// plus scoreboards of expected request addresses and decoded (pc, instr) pairs.
module tb_rapid_fetch;
    import rapid_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [1:0]  if_state;

    rapid_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_state       (if_state)
    );

    initial forever #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_addr[$];
    if_id_s      exp_out[$];
    int          cons_t[$];
    int          cyc = 0;
    int          lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
    endfunction

    task automatic push_req(input logic [31:0] a);
        exp_addr.push_back(a);
    endtask

    task automatic push_out(input logic [31:0] pc);
        if_id_s e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_out.push_back(e);
    endtask

    // One clock: monitor handshakes before the edge, advance the responder after it.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        if_id_s      e;
        #1;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        if (hs) begin
            if (exp_addr.size() > 0) check("req_addr", a, exp_addr.pop_front());
            else                     check("req_addr", a, 32'hDEAD_BEEF);
        end
        if (if_valid && if_ready && !redirect_valid && !reset) begin
            if (exp_out.size() > 0) e = exp_out.pop_front();
            else begin
                e.pc    = 32'hDEAD_BEEF;
                e.instr = 32'h0;
            end
            check("if_out", {if_pc, if_instr}, {e.pc, e.instr});
            cons_t.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (hs) begin
                pend      = 1'b1;
                cnt       = lat;
                pend_addr = a;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pend_addr);
                    pend            = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic run_out(input int left);
        int k = 0;
        while (exp_out.size() > left && k < 60) begin
            tick();
            k++;
        end
        check("drain", exp_out.size(), left);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!if_valid && k < 20) begin
            tick();
            k++;
        end
        check("if_valid_seen", if_valid, 1'b1);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        tick();
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        tick();
        reset = 1'b0;
        lat   = 1;
        cons_t.delete();
        #1;
        check("rst_state", if_state, FETCH);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_out", {if_pc, if_instr}, 64'h0);
        check("rst_req_addr", imem_req_addr, RESET_VECTOR);
    endtask

    task automatic end_phase();
        check("addr_q_empty", exp_addr.size(), 0);
    endtask

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        halt_req        = 1'b0;
        if_ready        = 1'b1;
        @(negedge clk);
        #1;

        // Sequential stream, 1-cycle memory, decode always ready.
        do_reset();
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_out(32'h0); push_out(32'h4); push_out(32'h8);
        run_out(0);
        if (cons_t.size() == 3) begin
            check("thruput_1", cons_t[1] - cons_t[0], 3);
            check("thruput_2", cons_t[2] - cons_t[1], 3);
        end else begin
            check("cons_count", cons_t.size(), 3);
        end
        end_phase();

        // Decode stalls the instruction at PC 0x4 for 5 cycles.
        do_reset();
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_out(32'h0); push_out(32'h4); push_out(32'h8);
        run_out(2);
        if_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_out", {if_pc, if_instr}, {32'h4, mem_word(32'h4)});
            check("stall_no_req", imem_req_valid, 1'b0);
            check("stall_state", if_state, NEXT);
            tick();
        end
        if_ready = 1'b1;
        run_out(0);
        end_phase();

        // Redirect to 0x103 while WAIT, before the response returns.
        do_reset();
        lat = 3;
        push_req(32'h0);
        tick();
        check("wait_state", if_state, WAIT);
        push_req(32'h100);
        push_out(32'h100);
        redirect(32'h0000_0103);
        lat = 1;
        run_out(0);
        end_phase();

        // Redirect coinciding with the handshake at 0x8.
        do_reset();
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_out(32'h0); push_out(32'h4);
        run_out(0);
        push_req(32'h40);
        push_out(32'h40);
        redirect(32'h40);
        check("squash_wait", if_state, WAIT);
        run_out(0);
        end_phase();

        // Halt requested in NEXT; only a redirect leaves HALT.
        do_reset();
        if_ready = 1'b0;
        push_req(32'h0);
        push_out(32'h0);
        wait_valid();
        halt_req = 1'b1;
        if_ready = 1'b1;
        tick();
        check("halt_state", if_state, HALT);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_no_req", imem_req_valid, 1'b0);
        end
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("halt_sticky", if_state, HALT);
        check("halt_sticky_req", imem_req_valid, 1'b0);
        push_req(32'h200);
        push_out(32'h200);
        redirect(32'h200);
        check("halt_exit", if_state, FETCH);
        run_out(0);
        end_phase();

        // PC wrap from 0xFFFFFFFC to 0.
        do_reset();
        imem_req_ready = 1'b0;
        redirect(32'hFFFF_FFFF);
        imem_req_ready = 1'b1;
        push_req(32'hFFFF_FFFC); push_req(32'h0);
        push_out(32'hFFFF_FFFC); push_out(32'h0);
        run_out(0);
        end_phase();

        // Reset in the middle of WAIT.
        lat = 3;
        push_req(32'h4);
        tick();
        check("pre_rst_wait", if_state, WAIT);
        do_reset();
        push_req(RESET_VECTOR);
        push_out(RESET_VECTOR);
        run_out(0);
        end_phase();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
